// File: rtl/serial_byte_collector.sv
// serial_byte_collector: assembles a serial bit stream into DATA_W-bit words behind a valid/ready output register
module serial_byte_collector #(
  parameter int DATA_W = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bit_in_i,
  input  logic                      bit_valid_i,
  output logic                      bit_ready_o,
  input  logic                      frame_start_i,
  output logic [DATA_W-1:0]         data_o,
  output logic                      data_valid_o,
  input  logic                      data_ready_i,
  output logic [$clog2(DATA_W)-1:0] bit_cnt_o,
  output logic                      overrun_o,
  input  logic                      overrun_clr_i
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic {COLLECT, HOLD} state_t;
  state_t state_q, state_d;
  logic [DATA_W-1:0] sreg_q, sreg_d, data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d, pos, idx;
  logic valid_q, valid_d, ovr_q, ovr_d, accept, take, done;
  always_comb begin
    pos = frame_start_i ? '0 : cnt_q;
    idx = LSB_FIRST ? pos : CW'(DATA_W-1) - pos;
    accept = bit_valid_i && state_q == COLLECT;
    take = valid_q && data_ready_i;
    done = accept && pos == CW'(DATA_W-1);
    sreg_d = sreg_q;
    if (accept) sreg_d[idx] = bit_in_i;
    cnt_d = state_q == HOLD ? cnt_q : done ? '0 : accept ? pos + 1'b1 : pos;
    state_d = state_q;
    data_d = data_q;
    valid_d = valid_q && !take;
    // A completed word waits in sreg (HOLD) only if the output register is still occupied
    if (state_q == HOLD && take) begin
      state_d = COLLECT;
      data_d = sreg_q;
      valid_d = 1'b1;
    end else if (done && (!valid_q || take)) begin
      data_d = sreg_d;
      valid_d = 1'b1;
    end else if (done) begin
      state_d = HOLD;
    end
    ovr_d = (bit_valid_i && state_q == HOLD) || (ovr_q && !overrun_clr_i);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      sreg_q <= '0;
      data_q <= '0;
      cnt_q <= '0;
      valid_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q <= sreg_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      ovr_q <= ovr_d;
    end
  end
  assign bit_ready_o = state_q == COLLECT;
  assign data_o = data_q;
  assign data_valid_o = valid_q;
  assign bit_cnt_o = cnt_q;
  assign overrun_o = ovr_q;
endmodule

// File: tb/tb_serial_byte_collector.sv
// tb_serial_byte_collector: random and directed stimulus against a word-queue reference model, LSB- and MSB-first instances
module tb_serial_byte_collector;
  logic clk = 1'b0, rst = 1'b1;
  logic bit_in = 1'b0, bit_valid = 1'b0, frame_start = 1'b0, data_ready = 1'b0, overrun_clr = 1'b0;
  logic [7:0] data_l, data_m;
  logic dv_l, dv_m, br_l, br_m, ov_l, ov_m;
  logic [2:0] bc_l, bc_m;
  int n_run = 0, n_fail = 0;
  bit run = 1'b0;
  logic [7:0] fifo[$];
  logic part[$];
  logic [7:0] last_w = 8'h00;
  logic m_ovr = 1'b0;

  always #5 clk = ~clk;

  serial_byte_collector #(.DATA_W(8), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst(rst), .bit_in_i(bit_in), .bit_valid_i(bit_valid), .bit_ready_o(br_l),
    .frame_start_i(frame_start), .data_o(data_l), .data_valid_o(dv_l), .data_ready_i(data_ready),
    .bit_cnt_o(bc_l), .overrun_o(ov_l), .overrun_clr_i(overrun_clr));
  serial_byte_collector #(.DATA_W(8), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst(rst), .bit_in_i(bit_in), .bit_valid_i(bit_valid), .bit_ready_o(br_m),
    .frame_start_i(frame_start), .data_o(data_m), .data_valid_o(dv_m), .data_ready_i(data_ready),
    .bit_cnt_o(bc_m), .overrun_o(ov_m), .overrun_clr_i(overrun_clr));

  function automatic logic [7:0] rev(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  function automatic logic [7:0] shown();
    return fifo.size() > 0 ? fifo[0] : last_w;
  endfunction

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // The visible word plus an optional held word behave as a two-entry queue
  task automatic model_step(input logic bv, b, fs, dr, oc);
    logic rdy;
    logic [7:0] w;
    rdy = fifo.size() < 2;
    if (fifo.size() > 0 && dr) last_w = fifo.pop_front();
    if (rdy) begin
      if (fs) part.delete();
      if (bv) part.push_back(b);
      if (part.size() == 8) begin
        for (int i = 0; i < 8; i++) w[i] = part[i];
        fifo.push_back(w);
        part.delete();
      end
    end
    m_ovr = (bv && !rdy) ? 1'b1 : oc ? 1'b0 : m_ovr;
  endtask

  task automatic model_reset();
    fifo.delete();
    part.delete();
    last_w = 8'h00;
    m_ovr = 1'b0;
  endtask

  task automatic cyc(input logic bv, b, fs, dr, oc);
    bit_valid = bv;
    bit_in = b;
    frame_start = fs;
    data_ready = dr;
    overrun_clr = oc;
    @(posedge clk);
    model_step(bv, b, fs, dr, oc);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] w, input logic dr);
    for (int i = 0; i < 8; i++) cyc(1'b1, w[i], 1'b0, dr, 1'b0);
  endtask

  always @(negedge clk) begin
    if (run && !rst) begin
      chk("data_lsb", data_l, shown());
      chk("data_msb", data_m, rev(shown()));
      chk("valid_lsb", 8'(dv_l), 8'(fifo.size() > 0));
      chk("valid_msb", 8'(dv_m), 8'(fifo.size() > 0));
      chk("ready_lsb", 8'(br_l), 8'(fifo.size() < 2));
      chk("ready_msb", 8'(br_m), 8'(fifo.size() < 2));
      chk("bitcnt_lsb", 8'(bc_l), 8'(part.size()));
      chk("bitcnt_msb", 8'(bc_m), 8'(part.size()));
      chk("overrun_lsb", 8'(ov_l), 8'(m_ovr));
      chk("overrun_msb", 8'(ov_m), 8'(m_ovr));
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_data", data_l, 8'h00);
    chk("rst_valid", 8'(dv_l), 8'h00);
    chk("rst_ready", 8'(br_l), 8'h01);
    chk("rst_bitcnt", 8'(bc_l), 8'h00);
    chk("rst_overrun", 8'(ov_l), 8'h00);
    rst = 1'b0;
    model_reset();
    run = 1'b1;
    @(negedge clk);
    send_word(8'hCD, 1'b1);
    chk("basic_data", data_l, 8'hCD);
    chk("basic_msb", data_m, 8'hB3);
    chk("basic_valid", 8'(dv_l), 8'h01);
    chk("basic_bitcnt", 8'(bc_l), 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("basic_valid_drop", 8'(dv_l), 8'h00);
    send_word(8'hFF, 1'b0);
    send_word(8'h0F, 1'b0);
    chk("bp_ready", 8'(br_l), 8'h00);
    chk("bp_data", data_l, 8'hFF);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovr_set", 8'(ov_l), 8'h01);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_sticky", 8'(ov_l), 8'h01);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_clr", 8'(ov_l), 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("ovr_set_wins", 8'(ov_l), 8'h01);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("bp_release_data", data_l, 8'h0F);
    chk("bp_release_valid", 8'(dv_l), 8'h01);
    chk("bp_release_ready", 8'(br_l), 8'h01);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (5) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("resync_bitcnt", 8'(bc_l), 8'h01);
    repeat (7) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("resync_data", data_l, 8'h01);
    chk("resync_msb", data_m, 8'h80);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("mid_bitcnt", 8'(bc_l), 8'h04);
    rst = 1'b1;
    #1;
    chk("arst_bitcnt", 8'(bc_l), 8'h00);
    chk("arst_data", data_l, 8'h00);
    chk("arst_valid", 8'(dv_l), 8'h00);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    send_word(8'hFF, 1'b1);
    chk("post_rst_word", data_l, 8'hFF);
    chk("post_rst_valid", 8'(dv_l), 8'h01);
    for (int k = 0; k < 3000; k++)
      cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 19) == 0,
          1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
    run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_byte_collector.md
# serial_byte_collector

Upstream feeder for the 8-bit majority voter. It accumulates a serial bit stream into DATA_W-bit words. Each completed word is presented on a registered parallel bus with a valid/ready handshake, so the voter (or any word consumer) always sees a stable, complete word. The block provides backpressure to the serial source, a resynchronising frame start, and a sticky overrun flag for bits dropped while it is stalled.

## Interface
- DATA_W, default 8: word width; must be ≥ 2. Fixed at 8 when feeding the voter.
- LSB_FIRST, default 1: 1 = first accepted bit lands in data[0]; 0 = first bit lands in data[DATA_W-1].
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  block accepts a bit this cycle. A bit is accepted when bit_valid & bit_ready.
- frame_start  input  1  discard any partial word; the bit accepted in the same cycle (if any) becomes bit 0.
- data  output  DATA_W  completed word; stable while data_valid=1.
- data_valid  output  1  data holds an unconsumed word.
- data_ready  input  1  consumer takes the word when data_valid & data_ready.
- bit_cnt  output  $clog2(DATA_W)  number of bits collected into the partial word.
- overrun  output  1  sticky; set when a bit is offered while bit_ready=0.
- overrun_clr  input  1  clears overrun. A simultaneous set takes priority.

## Operation
- Storage: shift/assembly register `sreg`, output register `data`, counter `bit_cnt`.
- State COLLECT (bit_ready=1):
  - An accepted bit is written at position bit_cnt (LSB_FIRST=1) or DATA_W-1-bit_cnt (LSB_FIRST=0), and bit_cnt increments.
  - On acceptance of bit DATA_W-1 (the word completes), there are two cases:
    - If data_valid=0, or data_valid & data_ready in the same cycle: load data with the full word, set data_valid=1, set bit_cnt=0, and stay in COLLECT.
    - Otherwise: keep the word in sreg, set bit_cnt=0, and go to HOLD.
- State HOLD (bit_ready=0):
  - On data_valid & data_ready, load data from sreg, keep data_valid=1, and go to COLLECT.
  - While in HOLD, bit_valid=1 sets overrun and the bit is dropped.
- frame_start:
  - In COLLECT, clears the partial word: bit_cnt=0, and sreg bits are don't-care (overwritten later).
  - A bit accepted in the same cycle is written as bit 0, and bit_cnt becomes 1.
  - In HOLD, frame_start is ignored because the held word is complete.
- data_valid clears on data_valid & data_ready when no new word is loaded in that same cycle.
- bit_cnt wraps from DATA_W-1 to 0 only on word completion. It never reaches DATA_W.

## Timing
- Reset values (asynchronous, effective immediately):
  - data=0, data_valid=0, bit_cnt=0, overrun=0.
  - State is COLLECT, so bit_ready=1.
  - sreg=0.
- Latency: data_valid rises on the clock edge that accepts the last bit. The word is visible in the cycle after that bit was presented.
- Throughput: one word per DATA_W cycles with no stalls. Back-to-back words need no idle cycle if the consumer keeps data_ready=1.
- bit_ready is a registered function of state. It does not depend combinationally on data_ready or bit_valid.
- data and data_valid are registers; there is no combinational path from inputs to them.
- Reset asserted mid-word or in HOLD:
  - The partial or held word is discarded.
  - All outputs take their reset values asynchronously.
  - The first bit accepted after reset deassertion is bit 0.

## Test plan
- Basic word: rst pulse; with LSB_FIRST=1, feed bits 1,0,1,1,0,0,1,1 one per cycle with data_ready=1 -> data=8'hCD, data_valid=1 for exactly 1 cycle, one cycle after the 8th bit; bit_cnt returns to 0.
- MSB-first: with LSB_FIRST=0, feed the same bits -> data=8'hB3.
- Backpressure: hold data_ready=0, then send word 8'hFF followed by 8'h0F:
  - After the second word completes, bit_ready=0 and the state is HOLD; data stays 8'hFF.
  - Raise data_ready for 1 cycle -> data=8'h0F, data_valid=1, bit_ready=1.
- Overrun: while in HOLD, drive bit_valid=1 for 3 cycles -> overrun=1 and stays 1; assert overrun_clr with no new violation -> overrun=0 the next cycle; assert overrun_clr together with a violating bit -> overrun stays 1.
- Resync: feed 5 bits, then assert frame_start with bit_valid=1, bit_in=1, then 7 bits of 0 -> data=8'h01; the 5 earlier bits do not appear.
- Reset mid-word: feed 4 bits, assert rst -> bit_cnt=0, data=0, data_valid=0 immediately; the next 8 bits form a clean word, e.g. all ones -> 8'hFF.
